// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU issue path: control codes, op classes,
// R-type funct values and the issue-stage state enumeration.
package alu_issue_stage_pkg;

  typedef enum logic [2:0] {
    CTRL_AND = 3'b000,
    CTRL_OR  = 3'b001,
    CTRL_ADD = 3'b010,
    CTRL_SUB = 3'b110,
    CTRL_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10,
    ALU_OP_RSVD  = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_TRAP  = 2'b10
  } stage_state_e;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational alu_op/funct decode into an ALU control code plus an
// illegal flag. Illegal ops still report ADD so 011 can never escape.
module alu_control_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] control,
  output logic       illegal
);

  // Map op class and funct field onto a control code
  always_comb begin
    control = CTRL_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALU_OP_ADD: control = CTRL_ADD;
      ALU_OP_SUB: control = CTRL_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FUNCT_ADD: control = CTRL_ADD;
          FUNCT_SUB: control = CTRL_SUB;
          FUNCT_AND: control = CTRL_AND;
          FUNCT_OR:  control = CTRL_OR;
          FUNCT_SLT: control = CTRL_SLT;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry issue buffer between decode and the ALU. Holds one decoded
// op with its operands, supports back-to-back issue, flush of the held
// entry, and a sticky trap for unsupported ops until acknowledged.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no entry held, ready to accept
// ST_FULL  | entry presented to the ALU (out_valid=1)
// ST_TRAP  | unsupported op trapped, waiting for illegal_ack
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [31:0]        src_a,
  input  logic [31:0]        src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         control,
  output logic [31:0]        a_out,
  output logic [31:0]        b_out,
  input  logic               flush,
  output logic               illegal,
  input  logic               illegal_ack,
  output logic [COUNT_W-1:0] issue_count
);

  stage_state_e state, next_state;
  logic [2:0]   dec_control;
  logic         dec_illegal;
  logic         accept;
  logic         consume;
  logic         load;

  alu_control_decode u_decode (
    .alu_op  (alu_op),
    .funct   (funct),
    .control (dec_control),
    .illegal (dec_illegal)
  );

  // Handshakes; a flushed entry is dropped, never counted as consumed
  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready & ~flush;
  assign load    = accept & ~dec_illegal;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EMPTY;
    else       state <= next_state;
  end

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      ST_EMPTY: begin
        if (accept) next_state = dec_illegal ? ST_TRAP : ST_FULL;
      end
      ST_FULL: begin
        if (flush)        next_state = ST_EMPTY;
        else if (accept)  next_state = dec_illegal ? ST_TRAP : ST_FULL;
        else if (consume) next_state = ST_EMPTY;
      end
      ST_TRAP: begin
        if (illegal_ack) next_state = ST_EMPTY;
      end
      default: next_state = ST_EMPTY;
    endcase
  end

  // State-derived handshake and status outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    illegal   = 1'b0;
    case (state)
      ST_EMPTY: in_ready = ~flush;
      ST_FULL: begin
        in_ready  = out_ready & ~flush;
        out_valid = 1'b1;
      end
      ST_TRAP:  illegal = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  // Entry register; only a legal accept overwrites it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control <= 3'b000;
      a_out   <= '0;
      b_out   <= '0;
    end else if (load) begin
      control <= dec_control;
      a_out   <= src_a;
      b_out   <= src_b;
    end
  end

  // Count entries taken by the execute stage, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        issue_count <= '0;
    else if (consume) issue_count <= issue_count + COUNT_W'(1);
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios plus random
// traffic, checked against an abstract held/trapped model with an entry queue.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'b0;
  logic [31:0] src_a = 32'b0;
  logic [31:0] src_b = 32'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  control;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic        flush = 1'b0;
  logic        illegal;
  logic        illegal_ack = 1'b0;
  logic [15:0] issue_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
  } entry_t;

  entry_t      exp_q[$];
  bit          m_held;
  bit          m_trap;
  logic [15:0] m_count;

  alu_issue_stage #(.COUNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .funct       (funct),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .control     (control),
    .a_out       (a_out),
    .b_out       (b_out),
    .flush       (flush),
    .illegal     (illegal),
    .illegal_ack (illegal_ack),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Decode rules written as a plain table lookup
  function automatic bit ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                    output logic [2:0] c);
    c = 3'b010;
    if (op == 2'd0) begin c = 3'b010; return 1'b1; end
    if (op == 2'd1) begin c = 3'b110; return 1'b1; end
    if (op == 2'd3) return 1'b0;
    case (fn)
      6'd32: c = 3'b010;
      6'd34: c = 3'b110;
      6'd36: c = 3'b000;
      6'd37: c = 3'b001;
      6'd42: c = 3'b111;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Monitor/model: evaluate the current cycle mid-period, then advance
  always @(negedge clk) begin
    bit          exp_rdy, consume, accept, legal;
    logic [2:0]  rc;
    entry_t      e;
    if (reset) begin
      m_held  = 1'b0;
      m_trap  = 1'b0;
      m_count = 16'd0;
      exp_q.delete();
    end else begin
      if (flush || m_trap) exp_rdy = 1'b0;
      else if (m_held)     exp_rdy = out_ready;
      else                 exp_rdy = 1'b1;
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_held});
      chk("illegal", {31'b0, illegal}, {31'b0, m_trap});
      chk("issue_count", {16'b0, issue_count}, {16'b0, m_count});
      chk("ctrl_not_011", {31'b0, control == 3'b011}, 32'd0);
      if (m_held && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("control", {29'b0, control}, {29'b0, e.c});
        chk("a_out", a_out, e.a);
        chk("b_out", b_out, e.b);
      end
      consume = m_held && out_ready && !flush;
      accept  = in_valid && exp_rdy;
      legal   = ref_decode(alu_op, funct, rc);
      if (consume) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_count = m_count + 16'd1;
      end
      if (m_trap) begin
        if (illegal_ack) m_trap = 1'b0;
      end else if (m_held && flush) begin
        m_held = 1'b0;
        exp_q.delete();
      end else begin
        if (consume) m_held = 1'b0;
        if (accept) begin
          if (legal) begin
            e.c = rc; e.a = src_a; e.b = src_b;
            exp_q.push_back(e);
            m_held = 1'b1;
          end else begin
            m_trap = 1'b1;
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic fl, input logic ack);
    @(posedge clk);
    #1;
    in_valid = v; alu_op = op; funct = fn; src_a = a; src_b = b;
    out_ready = ordy; flush = fl; illegal_ack = ack;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, ordy, 1'b0, 1'b0);
  endtask

  logic [5:0] fn_tab [6];

  initial begin
    fn_tab[0] = 6'd32; fn_tab[1] = 6'd34; fn_tab[2] = 6'd36;
    fn_tab[3] = 6'd37; fn_tab[4] = 6'd42; fn_tab[5] = 6'd0;

    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_control", {29'b0, control}, 32'd0);
    chk("rst_a_out", a_out, 32'd0);
    chk("rst_b_out", b_out, 32'd0);
    chk("rst_count", {16'b0, issue_count}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    // AND op with one consume
    drive(1'b1, 2'd2, 6'd36, 32'hF0F0_0000, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("and_control", {29'b0, control}, 32'd0);
    chk("and_a_out", a_out, 32'hF0F0_0000);
    idle(1'b1);
    chk("and_count", {16'b0, issue_count}, 32'd1);

    // Four back-to-back entries
    drive(1'b1, 2'd0, 6'd0,  32'd11, 32'd12, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 6'd0,  32'd21, 32'd22, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 6'd37, 32'd31, 32'd32, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 6'd42, 32'd41, 32'd42, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("burst_count", {16'b0, issue_count}, 32'd5);

    // Held entry, then flushed while out_ready=1
    drive(1'b1, 2'd1, 6'd0, 32'hAAAA_5555, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 2'd0, 6'd0, 32'hDEAD_BEEF, 32'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd0, 6'd0, 32'hDEAD_BEEF, 32'd7, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_count", {16'b0, issue_count}, 32'd5);

    // Illegal funct traps until acknowledged
    drive(1'b1, 2'd2, 6'd0, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
    repeat (5) idle(1'b1);
    chk("trap_illegal", {31'b0, illegal}, 32'd1);
    drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("ack_illegal", {31'b0, illegal}, 32'd0);
    chk("ack_in_ready", {31'b0, in_ready}, 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] op;
      logic [5:0] fn;
      op = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
      drive(1'($urandom_range(0, 3) != 0), op, fn, $urandom, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 3) == 0));
    end
    repeat (3) drive(1'b0, 2'd0, 6'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset while an entry is held
    drive(1'b1, 2'd0, 6'd0, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 6'd0, 32'd7, 32'd8, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_count", {16'b0, issue_count}, 32'd0);
    chk("async_a_out", a_out, 32'd0);
    @(posedge clk); #1; reset = 1'b0;

    // Counter wrap: 65535 consumes, then one more
    for (int i = 0; i < 65535; i++)
      drive(1'b1, 2'd0, 6'd0, i, ~i, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("count_ffff", {16'b0, issue_count}, 32'h0000_FFFF);
    drive(1'b1, 2'd1, 6'd0, 32'd9, 32'd10, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("count_wrap", {16'b0, issue_count}, 32'd0);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL change on the rising clock edge except on reset.
REQ-002 Ports, in order (name direction width meaning) SHALL be:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  upstream holds a decoded instruction
- in_ready  out  1  stage accepts this cycle
- alu_op  in  2  main-decoder ALU op class
- funct  in  6  R-type function field
- src_a, src_b  in  32  operands
- out_valid  out  1  entry presented to ALU
- out_ready  in  1  execute stage consumes entry
- control  out  3  ALU control code
- a_out, b_out  out  32  registered operands
- flush  in  1  discard held entry
- illegal  out  1  unsupported op trapped
- illegal_ack  in  1  clears trap
- issue_count  out  16  entries consumed downstream
REQ-003 Parameter COUNT_W, default 16, SHALL set the issue_count width.

Function
REQ-004 Decode: alu_op 00 -> 010 (add); 01 -> 110 (sub); 10 uses funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111 (slt); all other funct values and alu_op 11 SHALL be illegal.
REQ-005 Control code 011 SHALL never be driven on control.
REQ-006 States SHALL be EMPTY, FULL and TRAP.
REQ-007 in_ready SHALL be 1 in EMPTY, equal to out_ready in FULL, 0 in TRAP, and 0 whenever flush=1.
REQ-008 Accept occurs when in_valid and in_ready are both 1; a legal accept SHALL register control, a_out and b_out and go to FULL, one cycle latency.
REQ-009 An illegal accept SHALL go to TRAP, leave control/a_out/b_out unchanged, and assert illegal from the next cycle.
REQ-010 out_valid SHALL be 1 only in FULL; control/a_out/b_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-011 Consume occurs when out_valid and out_ready are both 1; issue_count SHALL increment by 1, wrapping from all-ones to 0.
REQ-012 In FULL, a simultaneous consume and legal accept SHALL load the new entry and remain FULL (back-to-back, no bubble).
REQ-013 In FULL, a consume without an accept SHALL go to EMPTY.
REQ-014 flush=1 in FULL SHALL go to EMPTY without counting, even when out_ready=1.
REQ-015 flush SHALL have no effect in EMPTY or TRAP.
REQ-016 In TRAP, illegal SHALL stay 1 until illegal_ack=1, then go to EMPTY with illegal=0 next cycle; illegal_ack outside TRAP SHALL be ignored.

Reset
REQ-017 Reset SHALL force EMPTY and drive out_valid=0, illegal=0, control=000, a_out=0, b_out=0, issue_count=0 immediately, independent of clk.
REQ-018 Reset asserted mid-handshake SHALL discard any held or trapped entry without counting it.

Structure
REQ-019 ALU control codes (ADD 010, SUB 110, AND 000, OR 001, SLT 111), alu_op encodings, funct codes and the state enumeration SHALL live in a shared package used by the decoder, this stage and the ALU.
REQ-020 The combinational funct/alu_op decode SHALL be one sub-module, alu_control_decode, returning control and an illegal flag.

Verification
REQ-021 The bench SHALL cover:
- alu_op=10, funct=100100, src_a=0xF0F0_0000, src_b=0xFFFF_0000, out_ready=1 -> next cycle out_valid=1, control=000, a_out=0xF0F0_0000; issue_count 0->1.
- Four legal entries on consecutive cycles, out_ready=1 -> out_valid held 1 four cycles, controls in order, issue_count=4.
- Entry held with out_ready=0 for 3 cycles -> in_ready=0, outputs stable; then flush=1 -> EMPTY, issue_count unchanged.
- alu_op=10, funct=000000 -> illegal=1, in_ready=0 for 5 cycles; illegal_ack=1 -> illegal=0, in_ready=1 next cycle.
- issue_count preset to 0xFFFF via 65535 consumes, one more consume -> 0x0000.
- Reset asserted between clock edges while FULL -> out_valid=0 and issue_count=0 at once, before the next edge.
